// File: rtl/ex_op_ldi_seq_pkg.sv
// Shared types for the execute-stage insert-code sequencer: FSM states,
// command FIFO entry layout and insert-code width.
package ex_op_ldi_seq_pkg;

    localparam int CODE_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              hi;
        logic              last;
    } fifo_entry_t;

endpackage

// File: rtl/ldi_field_insert.sv
// Combinational field insert: writes the low bits of an insert code into the
// top or bottom field of the selected 32-bit half; codes below 4 pass through.
module ldi_field_insert
    import ex_op_ldi_seq_pkg::*;
(
    input  logic [63:0]       val_i,
    input  logic [CODE_W-1:0] code_i,
    input  logic              hi_i,
    output logic [63:0]       val_o
);

    logic [3:0]  width_s;
    logic        top_s;
    logic        noop_s;
    logic [5:0]  shift_s;
    logic [31:0] mask_lo_s;
    logic [31:0] field_s;
    logic [31:0] half_s;
    logic [31:0] new_half_s;

    // Locate the leading one (later, higher bits override) and build the field.
    always_comb begin
        width_s = 4'd0;
        top_s   = 1'b0;
        for (int i = 2; i < CODE_W; i++) begin
            width_s = code_i[i] ? 4'(i - 1) : width_s;
            top_s   = code_i[i] ? code_i[i-1] : top_s;
        end
        noop_s     = (code_i[CODE_W-1:2] == '0);
        shift_s    = 6'd32 - {2'd0, width_s};
        mask_lo_s  = (32'd1 << width_s) - 32'd1;
        field_s    = {{(32-CODE_W){1'b0}}, code_i} & mask_lo_s;
        half_s     = hi_i ? val_i[63:32] : val_i[31:0];
        if (noop_s) begin
            new_half_s = half_s;
        end else if (top_s) begin
            new_half_s = (half_s & ~(mask_lo_s << shift_s)) | (field_s << shift_s);
        end else begin
            new_half_s = (half_s & ~mask_lo_s) | field_s;
        end
        if (hi_i) begin
            val_o = {new_half_s, val_i[31:0]};
        end else begin
            val_o = {val_i[63:32], new_half_s};
        end
    end

endmodule

// File: rtl/ex_op_ldi_seq.sv
// Insert-code sequencer: queues decode's insert groups in a small FIFO, applies
// one code per cycle to a working register and hands the result to writeback.
module ex_op_ldi_seq
    import ex_op_ldi_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              cmdValid,
    output logic              cmdReady,
    input  logic [CODE_W-1:0] cmdCode,
    input  logic              cmdHi,
    input  logic              cmdLast,
    input  logic [63:0]       cmdBase,
    output logic              resValid,
    input  logic              resReady,
    output logic [63:0]       resVal,
    output logic [3:0]        resCount
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    fifo_entry_t  mem_q [DEPTH];
    state_e       state_q;
    logic [63:0]  acc_q;
    logic [63:0]  res_val_q;
    logic         res_valid_q;
    logic [3:0]   count_q;
    logic         grp_open_q;
    logic         in_hold_q;

    logic         fifo_empty_s;
    logic         fifo_full_s;
    logic         push_s;
    logic         pop_s;
    fifo_entry_t  head_s;
    logic [63:0]  ins_val_s;

    assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
    assign fifo_full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign cmdReady     = reset & ~fifo_full_s & ~in_hold_q;
    assign push_s       = cmdValid & cmdReady & ~flush;
    assign pop_s        = (state_q == ST_APPLY) & ~fifo_empty_s & ~flush;
    assign head_s       = mem_q[rd_ptr_q[AW-1:0]];

    assign resValid = res_valid_q;
    assign resVal   = res_val_q;
    assign resCount = count_q;

    ldi_field_insert u_insert (
        .val_i  (acc_q),
        .code_i (head_s.code),
        .hi_i   (head_s.hi),
        .val_o  (ins_val_s)
    );

    // Command FIFO storage and wrap-bit pointers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= '{code: cmdCode, hi: cmdHi, last: cmdLast};
                wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Sequencer FSM with group tracking, working register and registered result.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= 64'd0;
            res_val_q   <= 64'd0;
            res_valid_q <= 1'b0;
            count_q     <= 4'd0;
            grp_open_q  <= 1'b0;
            in_hold_q   <= 1'b0;
        end else if (flush) begin
            state_q     <= ST_IDLE;
            res_valid_q <= 1'b0;
            count_q     <= 4'd0;
            grp_open_q  <= 1'b0;
            in_hold_q   <= 1'b0;
        end else begin
            if (push_s) begin
                if (!grp_open_q) begin
                    grp_open_q <= 1'b1;
                    acc_q      <= cmdBase;
                end
                if (cmdLast) begin
                    in_hold_q <= 1'b1;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (push_s && !grp_open_q) begin
                        state_q <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    if (pop_s) begin
                        acc_q <= ins_val_s;
                        if (count_q != 4'd15) begin
                            count_q <= count_q + 4'd1;
                        end
                        if (head_s.last) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // Result becomes visible one edge after the final apply.
                    if (!res_valid_q) begin
                        res_valid_q <= 1'b1;
                        res_val_q   <= acc_q;
                    end else if (resReady) begin
                        res_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                        count_q     <= 4'd0;
                        grp_open_q  <= 1'b0;
                        in_hold_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_op_ldi_seq.sv
// Directed bench for ex_op_ldi_seq: table of single-command groups plus
// hand-written multi-cycle sequences (long groups, flush, async reset).
module tb_ex_op_ldi_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        cmdValid = 1'b0;
    logic        cmdReady;
    logic [9:0]  cmdCode = 10'd0;
    logic        cmdHi = 1'b0;
    logic        cmdLast = 1'b0;
    logic [63:0] cmdBase = 64'd0;
    logic        resValid;
    logic        resReady = 1'b0;
    logic [63:0] resVal;
    logic [3:0]  resCount;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ex_op_ldi_seq #(.DEPTH(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .cmdValid (cmdValid),
        .cmdReady (cmdReady),
        .cmdCode  (cmdCode),
        .cmdHi    (cmdHi),
        .cmdLast  (cmdLast),
        .cmdBase  (cmdBase),
        .resValid (resValid),
        .resReady (resReady),
        .resVal   (resVal),
        .resCount (resCount)
    );

    typedef struct {
        logic [63:0] base;
        logic [9:0]  code;
        logic        hi;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_cmd(input logic [9:0] code, input logic hi, input logic last, input string tag);
        cmdCode  = code;
        cmdHi    = hi;
        cmdLast  = last;
        cmdValid = 1'b1;
        chk({tag, "_ready"}, {63'd0, cmdReady}, 64'd1);
        tick();
        cmdValid = 1'b0;
        cmdLast  = 1'b0;
    endtask

    task automatic wait_valid(input int budget, input string tag, output int n);
        n = 0;
        while (!resValid && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_valid_seen"}, {63'd0, resValid}, 64'd1);
    endtask

    task automatic handshake(input string tag);
        resReady = 1'b1;
        tick();
        resReady = 1'b0;
        chk({tag, "_hs_valid"}, {63'd0, resValid}, 64'd0);
        chk({tag, "_hs_ready"}, {63'd0, cmdReady}, 64'd1);
    endtask

    task automatic run_single(input logic [63:0] base, input logic [9:0] code, input logic hi,
                              input logic [63:0] exp, input string tag);
        cmdBase = base;
        send_cmd(code, hi, 1'b1, tag);
        chk({tag, "_valid_e0"}, {63'd0, resValid}, 64'd0);
        tick();
        chk({tag, "_valid_e1"}, {63'd0, resValid}, 64'd0);
        tick();
        chk({tag, "_valid_e2"}, {63'd0, resValid}, 64'd1);
        chk({tag, "_val"}, resVal, exp);
        chk({tag, "_count"}, {60'd0, resCount}, 64'd1);
        handshake(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic seen;
        logic [63:0] held;

        vecs[0] = '{64'h0, 10'h00A, 1'b0, 64'h0000_0000_0000_0002};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 10'h3A5, 1'b1, 64'hA5FF_FFFF_FFFF_FFFF};
        vecs[2] = '{64'h1234_5678_9ABC_DEF0, 10'h003, 1'b0, 64'h1234_5678_9ABC_DEF0};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 10'h004, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[4] = '{64'h0, 10'h007, 1'b1, 64'h8000_0000_0000_0000};
        vecs[5] = '{64'hFFFF_FFFF_0000_0000, 10'h1F0, 1'b0, 64'hFFFF_FFFF_E000_0000};
        vecs[6] = '{64'h0123_4567_89AB_CDEF, 10'h055, 1'b1, 64'h0123_4575_89AB_CDEF};

        // Reset state
        repeat (2) tick();
        chk("rst_valid", {63'd0, resValid}, 64'd0);
        chk("rst_val", resVal, 64'd0);
        chk("rst_count", {60'd0, resCount}, 64'd0);
        chk("rst_ready", {63'd0, cmdReady}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rel_ready", {63'd0, cmdReady}, 64'd1);
        tick();

        for (int i = 0; i < 7; i++) begin
            run_single(vecs[i].base, vecs[i].code, vecs[i].hi, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Three back-to-back commands
        cmdBase = 64'd0;
        send_cmd(10'h2C3, 1'b0, 1'b0, "g3_c0");
        send_cmd(10'h003, 1'b0, 1'b0, "g3_c1");
        send_cmd(10'h017, 1'b1, 1'b1, "g3_c2");
        chk("g3_hold", {63'd0, cmdReady}, 64'd0);
        tick();
        chk("g3_valid_e3", {63'd0, resValid}, 64'd0);
        tick();
        chk("g3_valid_e4", {63'd0, resValid}, 64'd1);
        chk("g3_val", resVal, 64'h0000_0007_0000_00C3);
        chk("g3_count", {60'd0, resCount}, 64'd3);
        handshake("g3");

        // Six-command group longer than the FIFO, result held
        cmdBase = 64'd0;
        send_cmd(10'h00A, 1'b0, 1'b0, "g6_c0");
        send_cmd(10'h00D, 1'b1, 1'b0, "g6_c1");
        send_cmd(10'h003, 1'b0, 1'b0, "g6_c2");
        send_cmd(10'h3FF, 1'b0, 1'b0, "g6_c3");
        send_cmd(10'h200, 1'b1, 1'b0, "g6_c4");
        send_cmd(10'h10C, 1'b0, 1'b1, "g6_c5");
        chk("g6_hold", {63'd0, cmdReady}, 64'd0);
        wait_valid(10, "g6", n);
        chk("g6_latency", 64'(n), 64'd2);
        chk("g6_val", resVal, 64'h4000_0000_FF00_000C);
        chk("g6_count", {60'd0, resCount}, 64'd6);
        held = resVal;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (resVal !== held || resValid !== 1'b1 || resCount !== 4'd6 || cmdReady !== 1'b0) begin
                seen = 1'b1;
            end
        end
        chk("g6_stable", {63'd0, seen}, 64'd0);
        handshake("g6");

        // Seventeen commands: count saturates at 15
        cmdBase = 64'h5555_AAAA_1234_0055;
        for (int i = 0; i < 17; i++) begin
            send_cmd(10'h003, 1'(i % 2), (i == 16) ? 1'b1 : 1'b0, $sformatf("g17_c%0d", i));
        end
        wait_valid(10, "g17", n);
        chk("g17_latency", 64'(n), 64'd2);
        chk("g17_val", resVal, 64'h5555_AAAA_1234_0055);
        chk("g17_count", {60'd0, resCount}, 64'd15);
        handshake("g17");

        // Flush after two of four commands, with a same-cycle offer
        cmdBase = 64'd0;
        send_cmd(10'h00A, 1'b0, 1'b0, "fl_c0");
        send_cmd(10'h00D, 1'b1, 1'b0, "fl_c1");
        flush    = 1'b1;
        cmdValid = 1'b1;
        cmdLast  = 1'b1;
        cmdCode  = 10'h3A5;
        cmdBase  = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        flush    = 1'b0;
        cmdValid = 1'b0;
        cmdLast  = 1'b0;
        chk("fl_ready", {63'd0, cmdReady}, 64'd1);
        chk("fl_count", {60'd0, resCount}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (resValid !== 1'b0) seen = 1'b1;
            tick();
        end
        chk("fl_no_valid", {63'd0, seen}, 64'd0);
        run_single(64'd0, 10'h00A, 1'b0, 64'h0000_0000_0000_0002, "fl_after");

        // Asynchronous reset mid-APPLY
        cmdBase = 64'd0;
        send_cmd(10'h2C3, 1'b0, 1'b0, "ar_c0");
        send_cmd(10'h017, 1'b1, 1'b0, "ar_c1");
        tick();
        chk("ar_mid_count", {60'd0, resCount}, 64'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_valid", {63'd0, resValid}, 64'd0);
        chk("ar_val", resVal, 64'd0);
        chk("ar_count", {60'd0, resCount}, 64'd0);
        chk("ar_ready", {63'd0, cmdReady}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("ar_rel_ready", {63'd0, cmdReady}, 64'd1);
        tick();
        run_single(64'hFFFF_FFFF_FFFF_FFFF, 10'h3A5, 1'b1, 64'hA5FF_FFFF_FFFF_FFFF, "ar_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
